ntru_mult_seq_ctrl: RTL and testbench

- Sequencer between the AXI4-Stream wrapper and the NTRU serial multiplier core (M AUs).
- Unpacks N input stream words into the core's coefficient RAMs (h, addend, ternary r), pulses core start and waits for done.
- Streams N result coefficients out with full AXI4-Stream backpressure.
- Owns all stream handshakes; the core sees only RAM write ports, a start/done pair and a result read port.

---
 rtl/ntru_mult_seq_ctrl_if.sv | 28 ++
 rtl/ntru_mult_seq_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_ntru_mult_seq_ctrl.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ntru_mult_seq_ctrl_if.sv
// Stream-side bundle for the NTRU multiplier sequencer: one input and one output AXI4-Stream.
// slave = sequencer side, master = wrapper/bench side.
interface ntru_mult_seq_ctrl_if #(
  parameter int D_WIDTH = 32
);
  logic [D_WIDTH-1:0] din_axis_tdata;
  logic               din_axis_tvalid;
  logic               din_axis_tlast;
  logic               din_axis_tready;
  logic [D_WIDTH-1:0] dout_axis_tdata;
  logic               dout_axis_tvalid;
  logic               dout_axis_tlast;
  logic               dout_axis_tready;

  modport slave (
    input  din_axis_tdata, din_axis_tvalid, din_axis_tlast,
    output din_axis_tready,
    output dout_axis_tdata, dout_axis_tvalid, dout_axis_tlast,
    input  dout_axis_tready
  );

  modport master (
    output din_axis_tdata, din_axis_tvalid, din_axis_tlast,
    input  din_axis_tready,
    input  dout_axis_tdata, dout_axis_tvalid, dout_axis_tlast,
    output dout_axis_tready
  );
endinterface

// File: rtl/ntru_mult_seq_ctrl.sv
// Sequencer between the AXI4-Stream wrapper and the NTRU serial multiplier core.
// Optional cycle counter for the core run is enabled with macro NTRU_SEQ_PERF_EN.
module ntru_mult_seq_ctrl #(
  parameter int N       = 11,
  parameter int Q_BITS  = 11,
  parameter int D_WIDTH = 32,
  parameter int A_BITS  = 4
) (
  input  logic              din_axis_aclk,
  input  logic              din_axis_areset,
  ntru_mult_seq_ctrl_if.slave axis,
  output logic              wr_en,
  output logic [A_BITS-1:0] wr_addr,
  output logic              wr_h_en,
  output logic [Q_BITS-1:0] wr_h,
  output logic [Q_BITS-1:0] wr_m,
  output logic [1:0]        wr_r,
  output logic              core_start,
  input  logic              core_done,
  output logic [A_BITS-1:0] res_addr,
  input  logic [Q_BITS-1:0] res_data,
  output logic              busy,
  output logic              err
`ifdef NTRU_SEQ_PERF_EN
  ,
  output logic [31:0]       perf_cycles
`endif
);

  localparam int W_BITS = 2*Q_BITS + 4;
  localparam logic [A_BITS-1:0] LAST = A_BITS'(N-1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_START, S_WAIT, S_READ, S_OUT
  } state_t;

  typedef struct packed {
    logic [1:0]        cmd;
    logic [Q_BITS-1:0] h;
    logic [Q_BITS-1:0] m;
    logic [1:0]        r;
  } word_t;

  state_t            state_q, state_d;
  logic [A_BITS-1:0] idx_q, idx_d;
  logic [A_BITS-1:0] ridx_q, ridx_d;
  logic              key_new_q, key_new_d;
  logic              err_q, err_d;
  logic              rd_vld_q;
  logic [Q_BITS-1:0] dout_q;
  logic [Q_BITS-1:0] dout_val;

  word_t w;
  logic  din_hs, dout_hs;
  logic  cmd_new, cmd_reuse, bad_r;

  assign w         = word_t'(axis.din_axis_tdata[W_BITS-1:0]);
  assign cmd_new   = (w.cmd == 2'b10);
  assign cmd_reuse = (w.cmd == 2'b00);
  assign bad_r     = (w.r == 2'b10);

  generate
    if (D_WIDTH > W_BITS) begin : g_pad
      logic unused_hi;
      assign unused_hi = &{1'b0, axis.din_axis_tdata[D_WIDTH-1:W_BITS]};
    end
  endgenerate

  // Input is only accepted while loading, and never while reset is held.
  assign axis.din_axis_tready = !din_axis_areset && (state_q == S_IDLE || state_q == S_LOAD);
  assign din_hs  = axis.din_axis_tvalid && axis.din_axis_tready;
  assign dout_hs = axis.dout_axis_tvalid && axis.dout_axis_tready;

  always_ff @(posedge din_axis_aclk) begin
    if (din_axis_areset) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      ridx_q    <= '0;
      key_new_q <= 1'b0;
      err_q     <= 1'b0;
      rd_vld_q  <= 1'b0;
      dout_q    <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      ridx_q    <= ridx_d;
      key_new_q <= key_new_d;
      err_q     <= err_d;
      rd_vld_q  <= (state_q == S_READ);
      if (rd_vld_q) dout_q <= res_data;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    ridx_d     = ridx_q;
    key_new_d  = key_new_q;
    err_d      = err_q;
    wr_en      = 1'b0;
    wr_addr    = '0;
    wr_h_en    = 1'b0;
    wr_h       = '0;
    wr_m       = '0;
    wr_r       = 2'b00;
    core_start = 1'b0;
    unique case (state_q)
      S_IDLE, S_LOAD: begin
        if (din_hs) begin
          wr_en   = 1'b1;
          wr_addr = idx_q;
          wr_h    = w.h;
          wr_m    = w.m;
          wr_r    = bad_r ? 2'b00 : w.r;
          // Word 0 fixes the key mode for the block and restarts error tracking.
          if (state_q == S_IDLE) begin
            key_new_d = cmd_new;
            wr_h_en   = cmd_new;
            err_d     = !(cmd_new || cmd_reuse);
          end else begin
            wr_h_en   = key_new_q;
          end
          if (bad_r) err_d = 1'b1;
          if (idx_q == LAST) begin
            if (!axis.din_axis_tlast) err_d = 1'b1;
            idx_d   = '0;
            state_d = S_START;
          end else if (axis.din_axis_tlast) begin
            err_d   = 1'b1;
            idx_d   = '0;
            state_d = S_IDLE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = S_LOAD;
          end
        end
      end
      S_START: begin
        core_start = 1'b1;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        if (core_done) begin
          ridx_d  = '0;
          state_d = S_READ;
        end
      end
      S_READ: state_d = S_OUT;
      S_OUT: begin
        // Each accepted beat goes back through READ: one bubble while the next word returns.
        if (dout_hs) begin
          if (ridx_q == LAST) begin
            ridx_d  = '0;
            state_d = S_IDLE;
          end else begin
            ridx_d  = ridx_q + 1'b1;
            state_d = S_READ;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Fresh read data goes straight out; the held copy keeps the beat stable under stall.
  assign dout_val              = rd_vld_q ? res_data : dout_q;
  assign axis.dout_axis_tvalid = (state_q == S_OUT);
  assign axis.dout_axis_tdata  = (state_q == S_OUT) ? {{(D_WIDTH-Q_BITS){1'b0}}, dout_val} : '0;
  assign axis.dout_axis_tlast  = (state_q == S_OUT) && (ridx_q == LAST);
  assign res_addr              = ridx_q;
  assign busy                  = (state_q != S_IDLE);
  assign err                   = err_q;

`ifdef NTRU_SEQ_PERF_EN
  logic [31:0] perf_cnt_q;
  logic [31:0] perf_inc;

  assign perf_inc = (perf_cnt_q == 32'hFFFF_FFFF) ? perf_cnt_q : perf_cnt_q + 32'd1;

  // The start cycle counts as 1, so the value latched at done includes both endpoints.
  always_ff @(posedge din_axis_aclk) begin
    if (din_axis_areset) begin
      perf_cnt_q  <= '0;
      perf_cycles <= '0;
    end else if (state_q == S_START) begin
      perf_cnt_q  <= 32'd1;
    end else if (state_q == S_WAIT) begin
      perf_cnt_q  <= perf_inc;
      if (core_done) perf_cycles <= perf_inc;
    end
  end
`endif

endmodule

// File: tb/tb_ntru_mult_seq_ctrl.sv
// Self-checking bench for ntru_mult_seq_ctrl: directed blocks, a simple core/RAM model,
// and a per-cycle compare process against a block-level expectation model.
module tb_ntru_mult_seq_ctrl;
  localparam int N = 11, Q_BITS = 11, D_WIDTH = 32, A_BITS = 4, CORE_LAT = 20;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ntru_mult_seq_ctrl_if #(.D_WIDTH(D_WIDTH)) axis();

  logic              wr_en, wr_h_en, core_start, core_done, busy, err;
  logic [A_BITS-1:0] wr_addr, res_addr;
  logic [Q_BITS-1:0] wr_h, wr_m, res_data;
  logic [1:0]        wr_r;
`ifdef NTRU_SEQ_PERF_EN
  logic [31:0]       perf_cycles;
`endif

  ntru_mult_seq_ctrl #(.N(N), .Q_BITS(Q_BITS), .D_WIDTH(D_WIDTH), .A_BITS(A_BITS)) dut (
    .din_axis_aclk(clk), .din_axis_areset(rst), .axis(axis),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_h_en(wr_h_en), .wr_h(wr_h), .wr_m(wr_m), .wr_r(wr_r),
    .core_start(core_start), .core_done(core_done), .res_addr(res_addr), .res_data(res_data),
    .busy(busy), .err(err)
`ifdef NTRU_SEQ_PERF_EN
    , .perf_cycles(perf_cycles)
`endif
  );

  int n_chk = 0, n_pass = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk_eq(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Core / RAM model: done CORE_LAT cycles after start, result i is i*3, 1-cycle read latency.
  initial begin
    int tmr;
    logic st;
    logic [A_BITS-1:0] ra;
    tmr = 0; core_done = 1'b0; res_data = '0;
    forever begin
      @(negedge clk);
      st = core_start; ra = res_addr;
      @(posedge clk); #1;
      res_data  = (ra < N) ? Q_BITS'(ra * 3) : '0;
      core_done = 1'b0;
      if (st) tmr = CORE_LAT - 1;
      else if (tmr > 0) begin
        tmr--;
        if (tmr == 0) core_done = 1'b1;
      end
    end
  end

  // Output backpressure: pattern 1,0,0,1 when enabled.
  bit         bp_mode = 1'b0;
  logic [3:0] bp_pat  = 4'b1001;
  always @(posedge clk) begin
    #1;
    axis.dout_axis_tready = bp_mode ? bp_pat[cyc % 4] : 1'b1;
  end

  typedef struct {int addr; bit h_en; int h; int m; int r;} wr_t;
  wr_t exp_wr[$];
  logic [Q_BITS-1:0] h_cap [N];
  logic [Q_BITS-1:0] m_cap [N];
  logic [1:0]        r_cap [N];
  int  wr_cnt = 0, start_cnt = 0, total_beats = 0, valid_cycles = 0;
  int  beat = 0, done_cyc = 0;
  bit  first_pend = 0, stall_prev = 0;
  logic [D_WIDTH-1:0] prev_data = '0;

  always @(negedge clk) begin
    if (!rst) begin
      if (wr_en) begin
        wr_cnt++;
        if (exp_wr.size() == 0) chk_eq("unexpected_write", wr_addr, -1);
        else begin
          wr_t e;
          e = exp_wr.pop_front();
          chk_eq("wr_addr", wr_addr, e.addr);
          chk_eq("wr_h_en", wr_h_en, e.h_en);
          chk_eq("wr_h", wr_h, e.h);
          chk_eq("wr_m", wr_m, e.m);
          chk_eq("wr_r", wr_r, e.r);
        end
        if (wr_addr < N) begin
          m_cap[wr_addr] = wr_m;
          r_cap[wr_addr] = wr_r;
          if (wr_h_en) h_cap[wr_addr] = wr_h;
        end
      end
      if (core_start) start_cnt++;
      if (core_done) begin done_cyc = cyc; first_pend = 1; end
      if (axis.dout_axis_tvalid && first_pend) begin
        chk_eq("first_tvalid_latency", cyc - done_cyc, 2);
        first_pend = 0;
      end
      if (stall_prev) begin
        chk_eq("stall_tvalid", axis.dout_axis_tvalid, 1);
        chk_eq("stall_tdata", axis.dout_axis_tdata, prev_data);
      end
      if (axis.dout_axis_tvalid) valid_cycles++;
      if (axis.dout_axis_tvalid && axis.dout_axis_tready) begin
        chk_eq("dout_tdata", axis.dout_axis_tdata, beat * 3);
        chk_eq("dout_tlast", axis.dout_axis_tlast, beat == N-1);
        beat = (beat == N-1) ? 0 : beat + 1;
        total_beats++;
      end
      stall_prev = axis.dout_axis_tvalid && !axis.dout_axis_tready;
      prev_data  = axis.dout_axis_tdata;
    end
  end

  logic [D_WIDTH-1:0] blk [N];
  bit exp_err;

  function automatic logic [D_WIDTH-1:0] mkw(input int cmd, input int h, input int m, input int r);
    logic [25:0] v;
    v = {cmd[1:0], h[10:0], m[10:0], r[1:0]};
    return D_WIDTH'(v);
  endfunction

  // Sends nw words of blk, tlast on word last_at (-1 = none); queues the writes it must cause.
  task automatic send_block(input int nw, input int last_at);
    int cmd0, r;
    bit ok;
    cmd0    = int'(blk[0][25:24]);
    exp_err = !(cmd0 == 2 || cmd0 == 0);
    for (int k = 0; k < nw; k++) begin
      r = int'(blk[k][1:0]);
      if (r == 2) exp_err = 1;
      exp_wr.push_back('{k, cmd0 == 2, int'(blk[k][23:13]), int'(blk[k][12:2]), (r == 2) ? 0 : r});
    end
    if (last_at != N-1) exp_err = 1;
    for (int k = 0; k < nw; k++) begin
      axis.din_axis_tvalid = 1'b1;
      axis.din_axis_tdata  = blk[k];
      axis.din_axis_tlast  = (k == last_at);
      ok = 0;
      for (int t = 0; t < 200; t++) begin
        @(negedge clk);
        if (axis.din_axis_tready) begin ok = 1; break; end
      end
      if (!ok) chk_eq("din_handshake_timeout", k, -1);
      @(posedge clk); #1;
    end
    axis.din_axis_tvalid = 1'b0;
    axis.din_axis_tlast  = 1'b0;
  endtask

  task automatic wait_beats(input int target);
    for (int t = 0; t < 2000; t++) begin
      if (total_beats >= target) break;
      tick(1);
    end
    chk_eq("beat_count", total_beats, target);
  endtask

  task automatic check_idle_outputs(input string tag);
    chk_eq({tag, "_busy"}, busy, 0);
    chk_eq({tag, "_dout_tvalid"}, axis.dout_axis_tvalid, 0);
    chk_eq({tag, "_dout_tdata"}, axis.dout_axis_tdata, 0);
    chk_eq({tag, "_dout_tlast"}, axis.dout_axis_tlast, 0);
    chk_eq({tag, "_wr_en"}, wr_en, 0);
    chk_eq({tag, "_core_start"}, core_start, 0);
    chk_eq({tag, "_res_addr"}, res_addr, 0);
    chk_eq({tag, "_din_tready"}, axis.din_axis_tready, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got time %0t, expected finish earlier", $time);
    $fatal(1);
  end

  initial begin
    int vc;
    axis.din_axis_tvalid = 1'b0;
    axis.din_axis_tdata  = '0;
    axis.din_axis_tlast  = 1'b0;
    rst = 1'b1;
    tick(3);
    @(negedge clk);
    check_idle_outputs("reset");
    chk_eq("reset_err", err, 0);
`ifdef NTRU_SEQ_PERF_EN
    chk_eq("reset_perf", perf_cycles, 0);
`endif
    @(posedge clk); #1;
    rst = 1'b0;
    tick(2);
    @(negedge clk);
    chk_eq("idle_tready", axis.din_axis_tready, 1);
    @(posedge clk); #1;

    // New-key load, no backpressure
    for (int k = 0; k < N; k++) blk[k] = mkw(2, 459, 445, 0);
    send_block(N, N-1);
    wait_beats(N);
    tick(3);
    chk_eq("A_err", err, exp_err);
    chk_eq("A_err_lit", err, 0);
    chk_eq("A_wr_cnt", wr_cnt, 11);
    chk_eq("A_starts", start_cnt, 1);
    chk_eq("A_h10", h_cap[10], 459);
    chk_eq("A_m0", m_cap[0], 445);
    chk_eq("A_busy", busy, 0);
`ifdef NTRU_SEQ_PERF_EN
    chk_eq("A_perf", perf_cycles, 21);
`endif

    // Reuse-key load with output backpressure
    bp_mode = 1'b1;
    for (int k = 0; k < N; k++) blk[k] = mkw(0, 7, k, 0);
    blk[2] = D_WIDTH'(53*8192 + 0*4 + 1);
    blk[5] = mkw(0, 7, 5, 3);
    send_block(N, N-1);
    wait_beats(2*N);
    tick(3);
    chk_eq("B_err", err, exp_err);
    chk_eq("B_r2", r_cap[2], 2'b01);
    chk_eq("B_r5", r_cap[5], 2'b11);
    chk_eq("B_h2_kept", h_cap[2], 459);
    chk_eq("B_starts", start_cnt, 2);
    bp_mode = 1'b0;

    // Early tlast on word 4, then a normal block
    for (int k = 0; k < N; k++) blk[k] = mkw(2, 100 + k, k, 0);
    send_block(5, 4);
    tick(30);
    @(negedge clk);
    chk_eq("C_err", err, exp_err);
    chk_eq("C_err_lit", err, 1);
    chk_eq("C_starts", start_cnt, 2);
    chk_eq("C_busy", busy, 0);
    chk_eq("C_tready", axis.din_axis_tready, 1);
    @(posedge clk); #1;
    for (int k = 0; k < N; k++) blk[k] = mkw(0, 1, 2*k, 1);
    send_block(N, N-1);
    wait_beats(3*N);
    tick(3);
    chk_eq("C2_err", err, 0);
    chk_eq("C2_starts", start_cnt, 3);

    // Illegal r on word 7
    for (int k = 0; k < N; k++) blk[k] = mkw(0, 5, k, 0);
    blk[7] = mkw(0, 5, 7, 2);
    send_block(N, N-1);
    wait_beats(4*N);
    tick(3);
    chk_eq("D_err", err, exp_err);
    chk_eq("D_err_lit", err, 1);
    chk_eq("D_r7", r_cap[7], 2'b00);
    chk_eq("D_starts", start_cnt, 4);

    // Reset while waiting for the core
    for (int k = 0; k < N; k++) blk[k] = mkw(2, 9, k, 0);
    send_block(N, N-1);
    for (int t = 0; t < 100; t++) begin
      if (start_cnt >= 5) break;
      tick(1);
    end
    chk_eq("E_started", start_cnt, 5);
    tick(5);
    chk_eq("E_busy_wait", busy, 1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_idle_outputs("E_rst");
    chk_eq("E_err", err, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    vc = valid_cycles;
    tick(40);
    chk_eq("E_no_output", valid_cycles - vc, 0);
    chk_eq("E_total_beats", total_beats, 4*N);
    chk_eq("E_pending_writes", exp_wr.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
